speaker_arbiter: RTL and testbench

SPEAKER_ARBITER -- requirements
Module: speaker_arbiter

---
 rtl/speaker_arbiter.sv | 153 +++++++++++++++
 tb/tb_speaker_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/speaker_arbiter.sv
// Speaker ownership arbiter: IDLE/OWN/GAP FSM with fixed priority and silent gaps.
// Define ARB_PREEMPT_EN to let higher-priority requesters preempt after MIN_HOLD cycles.
module speaker_arbiter #(
  parameter int GAP_CYCLES = 4,
  parameter int MIN_HOLD   = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] req,
  input  logic [3:0] note_kbd,
  input  logic [3:0] note_auto,
  input  logic [3:0] note_ui,
  output logic [2:0] grant,
  output logic [3:0] note_out,
  output logic       mute,
  output logic [7:0] handovers
);

  typedef enum logic [1:0] {
    IDLE,
    OWN,
    GAP
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] grant_q, grant_d;
  logic [3:0] note_q, note_d;
  logic [7:0] hold_q, hold_d;
  logic [7:0] gap_q, gap_d;
  logic [7:0] ho_q, ho_d;

  logic [2:0] pick;
  logic [3:0] pick_note;
  logic [3:0] own_note;
  logic       owner_req;
  logic       preempt;
  logic [7:0] ho_inc;

  always_comb begin
    pick = 3'b000;
    if (req[0])      pick = 3'b001;
    else if (req[1]) pick = 3'b010;
    else if (req[2]) pick = 3'b100;
  end

  always_comb begin
    pick_note = 4'd0;
    unique case (1'b1)
      pick[0]: pick_note = note_kbd;
      pick[1]: pick_note = note_auto;
      pick[2]: pick_note = note_ui;
      default: pick_note = 4'd0;
    endcase
  end

  always_comb begin
    own_note = 4'd0;
    unique case (1'b1)
      grant_q[0]: own_note = note_kbd;
      grant_q[1]: own_note = note_auto;
      grant_q[2]: own_note = note_ui;
      default:    own_note = 4'd0;
    endcase
  end

  assign owner_req = |(req & grant_q);
  assign ho_inc    = (ho_q == 8'hFF) ? ho_q : ho_q + 8'd1;

  // grant_q - 1 masks exactly the bits of higher priority than a one-hot owner
`ifdef ARB_PREEMPT_EN
  assign preempt = (hold_q == 8'(MIN_HOLD)) && |(req & (grant_q - 3'd1));
`else
  assign preempt = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    note_d  = note_q;
    hold_d  = hold_q;
    gap_d   = gap_q;
    ho_d    = ho_q;
    unique case (state_q)
      IDLE: begin
        grant_d = 3'b000;
        note_d  = 4'd0;
        if (|req) begin
          state_d = OWN;
          grant_d = pick;
          note_d  = pick_note;
          hold_d  = 8'd0;
          ho_d    = ho_inc;
        end
      end
      OWN: begin
        if (!owner_req || preempt) begin
          state_d = GAP;
          grant_d = 3'b000;
          note_d  = 4'd0;
          gap_d   = 8'd0;
        end else begin
          note_d = own_note;
          if (hold_q != 8'(MIN_HOLD)) hold_d = hold_q + 8'd1;
        end
      end
      GAP: begin
        if (gap_q == 8'(GAP_CYCLES - 1)) begin
          gap_d = 8'd0;
          if (|req) begin
            state_d = OWN;
            grant_d = pick;
            note_d  = pick_note;
            hold_d  = 8'd0;
            ho_d    = ho_inc;
          end else begin
            state_d = IDLE;
          end
        end else begin
          gap_d = gap_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = 3'b000;
        note_d  = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= 3'b000;
      note_q  <= 4'd0;
      hold_q  <= 8'd0;
      gap_q   <= 8'd0;
      ho_q    <= 8'd0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      note_q  <= note_d;
      hold_q  <= hold_d;
      gap_q   <= gap_d;
      ho_q    <= ho_d;
    end
  end

  assign grant     = grant_q;
  assign note_out  = note_q;
  assign mute      = (state_q != OWN);
  assign handovers = ho_q;

endmodule

// File: tb/tb_speaker_arbiter.sv
// Randomized and directed bench for speaker_arbiter against a
// cycle-level ownership model built from owner/gap/hold counters.
module tb_speaker_arbiter;

  localparam int GAP  = 4;
  localparam int HOLD = 8;
`ifdef ARB_PREEMPT_EN
  localparam bit PRE = 1'b1;
`else
  localparam bit PRE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] req;
  logic [3:0] nk, na, nu;
  logic [2:0] grant;
  logic [3:0] note_out;
  logic       mute;
  logic [7:0] handovers;
  logic [15:0] dut_out;

  int vectors = 0;
  int miscompares = 0;

  int m_own, m_hold, m_gap, m_ho;
  logic [3:0] m_note;

  speaker_arbiter #(.GAP_CYCLES(GAP), .MIN_HOLD(HOLD)) dut (
    .clk(clk),
    .reset(reset),
    .req(req),
    .note_kbd(nk),
    .note_auto(na),
    .note_ui(nu),
    .grant(grant),
    .note_out(note_out),
    .mute(mute),
    .handovers(handovers)
  );

  always #5 clk = ~clk;

  assign dut_out = {grant, note_out, mute, handovers};

  function automatic logic [3:0] note_in(int i);
    if (i == 0) return nk;
    if (i == 1) return na;
    return nu;
  endfunction

  function automatic int prio(logic [2:0] r);
    if (r[0]) return 0;
    if (r[1]) return 1;
    if (r[2]) return 2;
    return -1;
  endfunction

  function automatic logic [15:0] model_out();
    logic [2:0] g;
    logic [3:0] n;
    g = (m_own >= 0) ? 3'(1 << m_own) : 3'b000;
    n = (m_own >= 0) ? m_note : 4'd0;
    return {g, n, (m_own < 0), 8'(m_ho)};
  endfunction

  task automatic model_reset();
    m_own = -1;
    m_hold = 0;
    m_gap = 0;
    m_ho = 0;
    m_note = 4'd0;
  endtask

  task automatic model_enter();
    int p;
    p = prio(req);
    if (p >= 0) begin
      m_own = p;
      m_hold = 0;
      m_note = note_in(p);
      if (m_ho < 255) m_ho++;
    end
  endtask

  task automatic model_edge();
    if (m_own >= 0) begin
      if (!req[m_own]) begin
        m_own = -1;
        m_gap = GAP;
      end else if (PRE && m_hold == HOLD && prio(req) < m_own) begin
        m_own = -1;
        m_gap = GAP;
      end else begin
        if (m_hold < HOLD) m_hold++;
        m_note = note_in(m_own);
      end
    end else if (m_gap > 0) begin
      m_gap--;
      if (m_gap == 0) model_enter();
    end else begin
      model_enter();
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    req = 3'b000;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    req = 3'b111;
    nk = 4'd9;
    reset = 1'b1;
    #1;
    vectors++;
    if (dut_out !== 16'h0100) begin
      miscompares++;
      $display("FAIL reset_async: got %h expected %h", dut_out, 16'h0100);
    end
    model_reset();
    @(posedge clk);
    #1;
    vectors++;
    if (dut_out !== model_out()) begin
      miscompares++;
      $display("FAIL reset_held: got %h expected %h", dut_out, model_out());
    end
    req = 3'b000;
    reset = 1'b0;
  endtask

  task automatic test_first_grant();
    do_reset();
    na = 4'd5;
    req = 3'b010;
    tick();
    vectors++;
    if (dut_out !== {3'b010, 4'd5, 1'b0, 8'd1}) begin
      miscompares++;
      $display("FAIL first_grant: got %h expected %h", dut_out,
               {3'b010, 4'd5, 1'b0, 8'd1});
    end
  endtask

  task automatic test_priority_gap();
    logic [3:0] k;
    int muted;
    do_reset();
    k = 4'($urandom_range(1, 15));
    nk = k;
    na = 4'd7;
    nu = 4'd2;
    req = 3'b111;
    tick();
    vectors++;
    if (grant !== 3'b001 || note_out !== k) begin
      miscompares++;
      $display("FAIL prio_kbd: got %b/%h expected 001/%h", grant, note_out, k);
    end
    req = 3'b110;
    muted = 0;
    tick();
    repeat (GAP) begin
      vectors++;
      if (dut_out !== model_out()) begin
        miscompares++;
        $display("FAIL prio_gap_cycle: got %h expected %h", dut_out, model_out());
      end
      if (grant === 3'b000 && mute === 1'b1) muted++;
      tick();
    end
    vectors++;
    if (muted !== GAP || grant !== 3'b010 || note_out !== 4'd7) begin
      miscompares++;
      $display("FAIL prio_gap_then_auto: muted %0d grant %b note %h expected %0d 010 7",
               muted, grant, note_out, GAP);
    end
  endtask

  task automatic test_preempt();
    int own_cnt;
    int exp_cnt;
    logic [2:0] exp_g;
    do_reset();
    na = 4'd3;
    nk = 4'd11;
    req = 3'b010;
    tick();
    own_cnt = (grant === 3'b010) ? 1 : 0;
    repeat (2) begin
      tick();
      if (grant === 3'b010) own_cnt++;
    end
    req = 3'b011;
    repeat (14) begin
      tick();
      vectors++;
      if (dut_out !== model_out()) begin
        miscompares++;
        $display("FAIL preempt_cycle: got %h expected %h", dut_out, model_out());
      end
      if (grant === 3'b010) own_cnt++;
    end
    exp_cnt = PRE ? HOLD + 1 : 17;
    exp_g = PRE ? 3'b001 : 3'b010;
    vectors++;
    if (own_cnt !== exp_cnt || grant !== exp_g) begin
      miscompares++;
      $display("FAIL preempt_hold: own %0d grant %b expected %0d %b",
               own_cnt, grant, exp_cnt, exp_g);
    end
    req = 3'b001;
    tick();
    vectors++;
    if (dut_out !== model_out()) begin
      miscompares++;
      $display("FAIL preempt_release: got %h expected %h", dut_out, model_out());
    end
  endtask

  task automatic test_simul_release();
    do_reset();
    na = 4'd6;
    nk = 4'd12;
    req = 3'b010;
    tick();
    tick();
    req = 3'b001;
    tick();
    repeat (GAP) begin
      vectors++;
      if (dut_out !== model_out()) begin
        miscompares++;
        $display("FAIL simul_gap: got %h expected %h", dut_out, model_out());
      end
      tick();
    end
    vectors++;
    if (dut_out !== {3'b001, 4'd12, 1'b0, 8'd2}) begin
      miscompares++;
      $display("FAIL simul_regrant: got %h expected %h", dut_out,
               {3'b001, 4'd12, 1'b0, 8'd2});
    end
  endtask

  task automatic test_reset_mid_gap();
    do_reset();
    req = 3'b001;
    tick();
    req = 3'b000;
    tick();
    tick();
    reset = 1'b1;
    #1;
    vectors++;
    if (dut_out !== 16'h0100) begin
      miscompares++;
      $display("FAIL reset_mid_gap: got %h expected %h", dut_out, 16'h0100);
    end
    model_reset();
    req = 3'b100;
    nu = 4'd4;
    @(posedge clk);
    #1;
    reset = 1'b0;
    tick();
    vectors++;
    if (dut_out !== {3'b100, 4'd4, 1'b0, 8'd1}) begin
      miscompares++;
      $display("FAIL reset_then_idle_eval: got %h expected %h", dut_out,
               {3'b100, 4'd4, 1'b0, 8'd1});
    end
  endtask

  task automatic test_random();
    do_reset();
    repeat (800) begin
      if ($urandom_range(0, 9) < 3) req = 3'($urandom_range(0, 7));
      nk = 4'($urandom);
      na = 4'($urandom);
      nu = 4'($urandom);
      tick();
      vectors++;
      if (dut_out !== model_out()) begin
        miscompares++;
        $display("FAIL random: req %b got %h expected %h", req, dut_out, model_out());
      end
    end
  endtask

  task automatic test_saturate();
    do_reset();
    nk = 4'd1;
    repeat (300) begin
      req = 3'b001;
      tick();
      req = 3'b000;
      repeat (GAP + 1) tick();
      vectors++;
      if (dut_out !== model_out()) begin
        miscompares++;
        $display("FAIL saturate_cycle: got %h expected %h", dut_out, model_out());
      end
    end
    vectors++;
    if (handovers !== 8'd255) begin
      miscompares++;
      $display("FAIL saturate_final: got %0d expected 255", handovers);
    end
  endtask

  initial begin
    reset = 1'b1;
    req = 3'b000;
    nk = 4'd0;
    na = 4'd0;
    nu = 4'd0;
    model_reset();
    test_reset();
    test_first_grant();
    test_priority_gap();
    test_preempt();
    test_simul_release();
    test_reset_mid_gap();
    test_random();
    test_saturate();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
